mux_load_shift_reg: RTL
=======================

Name: mux_load_shift_reg

Overview:
- Parametrised successor to the two-input select-and-load flip-flop.
- WIDTH-bit register with four modes:
  - hold
  - shift right
  - shift left
  - parallel load, with the source picked from NUM_SRC data channels.
- Tracks shifts since the last load and flags when the loaded word has been fully shifted out.
- Serves as the general storage and serialisation element for the chapter 5/6 register-transfer exercises.

Parameters:
- WIDTH, 8, register width in bits; must be ≥ 2.
- NUM_SRC, 4, number of parallel-load channels; must be ≥ 2.
- SEL_W, $clog2(NUM_SRC), width of the source select. Derived; do not override.
- CNT_W, $clog2(WIDTH+1), width of the shift counter. Derived.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-low reset.
- mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 load.
- sel  input  SEL_W  load source index.
- din  input  NUM_SRC*WIDTH  flattened channels; channel k is din[k*WIDTH +: WIDTH].
- sr_in  input  1  serial input entering the MSB on shift right.
- sl_in  input  1  serial input entering the LSB on shift left.
- q  output  WIDTH  register contents.
- shift_cnt  output  CNT_W  shifts since last load, saturating at WIDTH.
- drained  output  1  high when shift_cnt == WIDTH.

Behaviour:
- Reset: clear low asynchronously forces q = 0, shift_cnt = 0 and drained = 0, regardless of clk. This has priority over every mode. Release is synchronous-safe: the first active edge after clear rises performs the requested mode.
- Latency: all operations take effect at the first rising edge. q, shift_cnt and drained are registered; there is no combinational path from inputs to outputs.
- Hold (00): q and shift_cnt unchanged.
- Shift right (01): q <= {sr_in, q[WIDTH-1:1]}. shift_cnt increments, saturating at WIDTH.
- Shift left (10): q <= {q[WIDTH-2:0], sl_in}. shift_cnt increments, saturating at WIDTH.
- Load (11):
  - q <= din channel sel; shift_cnt <= 0.
  - sel >= NUM_SRC (only possible when NUM_SRC is not a power of two) loads all zeros. shift_cnt still clears.
- drained:
  - Registered; equal to (next shift_cnt == WIDTH).
  - Stays high through further shifts and holds.
  - Cleared only by a load or by clear.
- Direction changes mid-word (right then left) still count each shift; the counter counts operations, not net displacement.
- Reset mid-operation: the partially shifted word is lost; there is no recovery.
- Unknown or X mode is treated as hold.

Optional Feature:
- Macro: MUX_LOAD_SHIFT_REG_ROTATE_EN.
- Defined: shifts rotate.
  - Right: q <= {q[0], q[WIDTH-1:1]}.
  - Left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - sr_in and sl_in are ignored. Counter and drained behave as above; after WIDTH rotations q equals the loaded word.
- Undefined: serial inputs are used as specified in Behaviour; the sr_in/sl_in ports exist in both builds.

Decomposition:
- Package msr_pkg:
  - mode constants MODE_HOLD = 2'b00, MODE_SHR = 2'b01, MODE_SHL = 2'b10, MODE_LOAD = 2'b11
  - typedef mode_t (2-bit)
- Sub-module src_mux:
  - parametrised WIDTH/NUM_SRC combinational channel select
  - zero default for an out-of-range sel
  - instantiated once.
- Shifter and counter stay in the top module.

Test Plan:
1. Reset: with q = 8'hA5, pulse clear low between clock edges -> q = 8'h00, shift_cnt = 0 and drained = 0 immediately, before the next edge.
2. Load sweep: din = {8'h44, 8'h33, 8'h22, 8'h11}, mode = 11, sel = 0..3 on successive edges -> q = 8'h11, 8'h22, 8'h33, 8'h44; shift_cnt = 0 each time.
3. Drain right: load 8'hF0, then 8 shifts right with sr_in = 0 -> q = 8'h00. shift_cnt reaches 8 and saturates; drained rises after the 8th edge and stays high through 2 extra shifts.
4. Shift left, serial in: load 8'h00, 4 shifts left with sl_in = 1 -> q = 8'h0F, shift_cnt = 4, drained = 0. A hold cycle leaves all outputs unchanged.
5. Reload mid-drain: load 8'h81, 3 shifts, then load channel 2 (8'h33) -> q = 8'h33, shift_cnt = 0, drained = 0.
6. Rotate build (macro defined): load 8'h81, 8 shifts right with sr_in = 0 -> q = 8'h81, drained = 1. After 1 shift left from the loaded word, q = 8'h03.

Source files
------------

// File: rtl/msr_pkg.sv
// msr_pkg: operation encodings shared by the mux-load shift register and its bench.
package msr_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;
endpackage

// File: rtl/src_mux.sv
// src_mux: picks one WIDTH-bit channel out of a flattened bus; out-of-range select yields zero.
module src_mux #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] din,
  output logic [WIDTH-1:0]         dout
);
  always_comb begin
    dout = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (sel == SEL_W'(k)) dout = din[k*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/mux_load_shift_reg.sv
// mux_load_shift_reg: WIDTH-bit hold/shift/load register with drain counter.
// Define MUX_LOAD_SHIFT_REG_ROTATE_EN to make shifts rotate instead of taking sr_in/sl_in.
module mux_load_shift_reg
  import msr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] din,
  input  logic                     sr_in,
  input  logic                     sl_in,
  output logic [WIDTH-1:0]         q,
  output logic [CNT_W-1:0]         shift_cnt,
  output logic                     drained
);
  logic [WIDTH-1:0] r_q, w_load, w_q_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_drained, w_shr_in, w_shl_in;

  src_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_src_mux (
    .sel (sel),
    .din (din),
    .dout(w_load)
  );

`ifdef MUX_LOAD_SHIFT_REG_ROTATE_EN
  assign w_shr_in = r_q[0];
  assign w_shl_in = r_q[WIDTH-1];
`else
  assign w_shr_in = sr_in;
  assign w_shl_in = sl_in;
`endif

  // counter counts operations, not displacement, and saturates at WIDTH
  assign w_cnt_inc = (r_cnt == CNT_W'(WIDTH)) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_q_nxt   = r_q;
    w_cnt_nxt = r_cnt;
    case (mode_t'(mode))
      MODE_SHR: begin
        w_q_nxt   = {w_shr_in, r_q[WIDTH-1:1]};
        w_cnt_nxt = w_cnt_inc;
      end
      MODE_SHL: begin
        w_q_nxt   = {r_q[WIDTH-2:0], w_shl_in};
        w_cnt_nxt = w_cnt_inc;
      end
      MODE_LOAD: begin
        w_q_nxt   = w_load;
        w_cnt_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_q       <= '0;
      r_cnt     <= '0;
      r_drained <= 1'b0;
    end else begin
      r_q       <= w_q_nxt;
      r_cnt     <= w_cnt_nxt;
      r_drained <= (w_cnt_nxt == CNT_W'(WIDTH));
    end
  end

  assign q         = r_q;
  assign shift_cnt = r_cnt;
  assign drained   = r_drained;
endmodule
